rvv_lane_alu_seq: RTL

// Multi-lane, multi-cycle RVV integer ALU sequencer. It accepts one whole vector

---
 rtl/rvv_lane_alu_seq.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/rvv_lane_alu_seq.sv
// rtl/rvv_lane_alu_seq.sv - multi-lane multi-cycle RVV integer ALU sequencer
module rvv_lane_alu_seq #(
  parameter  int VLEN     = 128,
  parameter  int LANE_W   = 32,
  parameter  int NB_LANES = 2,
  localparam int VLW      = $clog2(VLEN/8) + 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [5:0]      op,
  input  logic [2:0]      op_type,
  input  logic [2:0]      vsew,
  input  logic [VLW-1:0]  vl,
  input  logic            vm,
  input  logic [VLEN-1:0] v0,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] vs2,
  input  logic [VLEN-1:0] vd_old,
  input  logic [63:0]     scalar,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [VLEN-1:0] vd
);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_RSUB = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b001001;
  localparam logic [5:0] OP_OR   = 6'b001010;
  localparam logic [5:0] OP_XOR  = 6'b001011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // per-lane compare state for min/max, decided by the first unequal chunk
  localparam logic [1:0] CMP_UND = 2'd0;
  localparam logic [1:0] CMP_LT  = 2'd1;
  localparam logic [1:0] CMP_GE  = 2'd2;

  logic [1:0]                 state_q;
  logic [5:0]                 op_q;
  logic                       vv_q;
  logic [1:0]                 sew_q;
  logic [VLW-1:0]             vl_q;
  logic                       vm_q;
  logic [VLEN-1:0]            v0_q;
  logic [VLEN-1:0]            vs1_q;
  logic [VLEN-1:0]            vs2_q;
  logic [63:0]                scalar_q;
  logic [VLEN-1:0]            vd_q;
  logic                       illegal_q;
  logic [VLW-1:0]             group_q;
  logic [2:0]                 chunk_q;
  logic [NB_LANES-1:0]        carry_q;
  logic [NB_LANES-1:0][1:0]   cmp_q;

  logic [VLEN-1:0]            vd_n;
  logic [NB_LANES-1:0]        carry_n;
  logic [NB_LANES-1:0][1:0]   cmp_n;

  logic in_vv, in_vi, in_onehot, in_mm, in_legal_op, in_illegal;
  logic is_mm;
  int   sew_bits, n_chunks, cw;
  logic [LANE_W-1:0] cmask;
  logic [63:0]       emask;
  logic last_chunk, last_group;

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign illegal = illegal_q;
  assign vd      = vd_q;

  // legality of the request currently on the inputs
  always_comb begin
    in_vv       = (op_type == 3'b001);
    in_vi       = (op_type == 3'b100);
    in_onehot   = in_vv || (op_type == 3'b010) || in_vi;
    in_mm       = (op[5:2] == 4'b0001);
    in_legal_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_RSUB) || in_mm ||
                  (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
    in_illegal  = vsew[2] || !in_legal_op || !in_onehot ||
                  ((op == OP_SUB) && in_vi) || ((op == OP_RSUB) && in_vv) ||
                  (in_mm && in_vi);
  end

  // beat geometry: chunk width/count for the latched SEW and end-of-run detection
  always_comb begin
    is_mm    = (op_q[5:2] == 4'b0001);
    sew_bits = 8 << sew_q;
    n_chunks = (sew_bits > LANE_W) ? sew_bits / LANE_W : 1;
    cw       = (sew_bits > LANE_W) ? LANE_W : sew_bits;
    cmask    = '1;
    if (cw < LANE_W) cmask = (LANE_W'(1) << cw) - LANE_W'(1);
    emask    = '1;
    if (sew_bits < 64) emask = (64'd1 << sew_bits) - 64'd1;
    last_chunk = (int'(chunk_q) == n_chunks - 1);
    last_group = ((int'(group_q) + 1) * NB_LANES >= int'(vl_q));
  end

  // lane datapath: one chunk per lane per beat, merged into the next vd image
  always_comb begin
    int e, k, off;
    logic act, cin, lt;
    logic [LANE_W-1:0] a_c, b_c, x, y, r_c, sbit;
    logic [LANE_W:0]   sum;
    logic [1:0]        st;
    logic [63:0]       ea, eb, pick;
    logic [VLEN-1:0]   wmask;
    vd_n    = vd_q;
    carry_n = carry_q;
    cmp_n   = cmp_q;
    e = 0; k = 0; off = 0; act = 1'b0; cin = 1'b0; lt = 1'b0;
    a_c = '0; b_c = '0; x = '0; y = '0; r_c = '0; sbit = '0; sum = '0;
    st = CMP_UND; ea = '0; eb = '0; pick = '0; wmask = '0;
    for (int l = 0; l < NB_LANES; l++) begin
      e   = int'(group_q) * NB_LANES + l;
      k   = is_mm ? (n_chunks - 1 - int'(chunk_q)) : int'(chunk_q);
      off = e * sew_bits + k * cw;
      act = (e < int'(vl_q)) && (vm_q || v0_q[e]);
      b_c = LANE_W'(vs2_q >> off) & cmask;
      a_c = vv_q ? (LANE_W'(vs1_q >> off) & cmask) : (LANE_W'(scalar_q >> (k * cw)) & cmask);

      // carry chain: subtraction injects +1 at chunk 0, later chunks take the lane carry
      cin = (chunk_q == 3'd0) ? ((op_q == OP_SUB) || (op_q == OP_RSUB)) : carry_q[l];
      x   = (op_q == OP_RSUB) ? a_c : b_c;
      y   = (op_q == OP_SUB) ? ~a_c : ((op_q == OP_RSUB) ? ~b_c : a_c);
      sum = {1'b0, x} + {1'b0, y} + {{LANE_W{1'b0}}, cin};
      case (op_q)
        OP_AND:  r_c = b_c & a_c;
        OP_OR:   r_c = b_c | a_c;
        OP_XOR:  r_c = b_c ^ a_c;
        default: r_c = sum[LANE_W-1:0];
      endcase

      // only the most significant chunk of a signed compare sees the sign bit
      sbit = '0;
      if (op_q[0] && (k == n_chunks - 1)) sbit = LANE_W'(1) << (cw - 1);
      st = (chunk_q == 3'd0) ? CMP_UND : cmp_q[l];
      if ((st == CMP_UND) && ((b_c ^ sbit) != (a_c ^ sbit)))
        st = ((b_c ^ sbit) < (a_c ^ sbit)) ? CMP_LT : CMP_GE;
      lt   = (st == CMP_LT);
      eb   = 64'(vs2_q >> (e * sew_bits)) & emask;
      ea   = vv_q ? (64'(vs1_q >> (e * sew_bits)) & emask) : (scalar_q & emask);
      pick = op_q[1] ? (lt ? ea : eb) : (lt ? eb : ea);

      if (act) begin
        if (is_mm) begin
          cmp_n[l] = st;
          if (last_chunk) begin
            wmask = VLEN'(emask) << (e * sew_bits);
            vd_n  = (vd_n & ~wmask) | ((VLEN'(pick) << (e * sew_bits)) & wmask);
          end
        end else begin
          carry_n[l] = sum[LANE_W];
          wmask = VLEN'(cmask) << off;
          vd_n  = (vd_n & ~wmask) | ((VLEN'(r_c) << off) & wmask);
        end
      end
    end
  end

  // sequencer: accept and latch in IDLE, walk groups x chunks in RUN, pulse DONE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      vv_q      <= 1'b0;
      sew_q     <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      v0_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      scalar_q  <= '0;
      vd_q      <= '0;
      illegal_q <= 1'b0;
      group_q   <= '0;
      chunk_q   <= '0;
      carry_q   <= '0;
      cmp_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q      <= op;
            vv_q      <= in_vv;
            sew_q     <= vsew[1:0];
            vl_q      <= vl;
            vm_q      <= vm;
            v0_q      <= v0;
            vs1_q     <= vs1;
            vs2_q     <= vs2;
            scalar_q  <= scalar;
            vd_q      <= vd_old;
            illegal_q <= in_illegal;
            group_q   <= '0;
            chunk_q   <= '0;
            carry_q   <= '0;
            cmp_q     <= '0;
            state_q   <= (in_illegal || (vl == '0)) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          vd_q    <= vd_n;
          carry_q <= carry_n;
          cmp_q   <= cmp_n;
          if (last_chunk) begin
            chunk_q <= '0;
            if (last_group) state_q <= S_DONE;
            else            group_q <= group_q + VLW'(1);
          end else begin
            chunk_q <= chunk_q + 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
